// File: rtl/sd_demodulator.sv
// -----------------------------------------------------------------------------
// sd_demodulator
//
// Receive half of a first-order 1-bit sigma-delta ADC built from an external
// comparator and RC integrator. The comparator bit is re-timed through a
// two-flop synchronizer. The synchronized bit is returned on oFB to close the
// analog loop. The bitstream is decimated by R = 2^pDEC_BITS with a
// third-order CIC filter and emitted as unsigned PCM.
//
// Parameters
//   pBITS      output sample width (pBITS <= 3*pDEC_BITS)
//   pDEC_BITS  log2 of the decimation ratio R
//
// Ports
//   iCLK     system clock, rising edge
//   iRESETn  asynchronous active-low reset (release is synchronous to iCLK)
//   iBIT     raw comparator bit, asynchronous to iCLK
//   oFB      feedback bit to the RC integrator (synchronized iBIT)
//   oDATA    decimated unsigned sample, held between strobes
//   oSTROBE  one-cycle pulse marking a new oDATA, period exactly R cycles
// -----------------------------------------------------------------------------
module sd_demodulator #(
    parameter int pBITS     = 8,
    parameter int pDEC_BITS = 5
) (
    input  logic             iCLK,
    input  logic             iRESETn,
    input  logic             iBIT,
    output logic             oFB,
    output logic [pBITS-1:0] oDATA,
    output logic             oSTROBE
);

    // Integrator width: enough headroom for R^3 gain plus one bit so that
    // full scale (exactly R^3) is representable before saturation.
    localparam int W     = 3*pDEC_BITS + 1;
    localparam int SHIFT = W - 1 - pBITS;

    localparam logic [pDEC_BITS-1:0] TC_VAL     = '1;
    localparam logic [W-1:0]         FULL_SCALE = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]         MAX_POS    = {1'b0, {(W-1){1'b1}}};
    localparam logic [2:0]           WARM_DONE  = 3'd4;

    logic                 s1Reg;
    logic                 s2Reg;
    logic [W-1:0]         integReg [3];
    logic [W-1:0]         integIn  [3];
    logic [W-1:0]         combReg  [4];
    logic [pDEC_BITS-1:0] decCntReg;
    logic                 tcDlyReg;
    logic [2:0]           warmReg;
    logic [pBITS-1:0]     dataReg;
    logic                 strobeReg;

    logic [W-1:0]         diffNext;
    logic [W-1:0]         yNext;
    logic [W-1:0]         ysNext;
    logic [pBITS-1:0]     dataNext;

    // Integrator cascade inputs: first stage takes the synchronized bit,
    // each later stage takes the previous stage's accumulator.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : gInteg
            if (gi == 0) begin : gFirst
                assign integIn[gi] = {{(W-1){1'b0}}, s2Reg};
            end else begin : gRest
                assign integIn[gi] = integReg[gi-1];
            end
        end
    endgenerate

    // Comb: c0 - 3*c1 + 3*c2 - c3, all modulo 2^W. Integrator wrap-around
    // cancels here, which is why the accumulators never saturate.
    always_comb begin
        diffNext = combReg[2] - combReg[1];
        yNext    = combReg[0] - combReg[3] + diffNext + (diffNext << 1);
        // A constant-1 input produces exactly 2^(W-1), one past the largest
        // value the top output bits can express; clip it to all-ones.
        ysNext   = (yNext == FULL_SCALE) ? MAX_POS : yNext;
        dataNext = pBITS'(ysNext >> SHIFT);
    end

    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            s1Reg     <= 1'b0;
            s2Reg     <= 1'b0;
            decCntReg <= '0;
            tcDlyReg  <= 1'b0;
            warmReg   <= '0;
            dataReg   <= '0;
            strobeReg <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                integReg[k] <= '0;
            end
            for (int k = 0; k < 4; k++) begin
                combReg[k] <= '0;
            end
        end else begin
            s1Reg     <= iBIT;
            s2Reg     <= s1Reg;
            decCntReg <= decCntReg + 1'b1;
            tcDlyReg  <= (decCntReg == TC_VAL);

            for (int k = 0; k < 3; k++) begin
                integReg[k] <= integReg[k] + integIn[k];
            end

            if (decCntReg == TC_VAL) begin
                combReg[0] <= integReg[2];
                for (int k = 1; k < 4; k++) begin
                    combReg[k] <= combReg[k-1];
                end
            end

            // The first four decimated samples are discarded while the comb
            // delay line fills; the strobe cadence itself never shifts.
            strobeReg <= 1'b0;
            if (tcDlyReg) begin
                if (warmReg == WARM_DONE) begin
                    strobeReg <= 1'b1;
                    dataReg   <= dataNext;
                end else begin
                    warmReg <= warmReg + 3'd1;
                end
            end
        end
    end

    assign oFB     = s2Reg;
    assign oDATA   = dataReg;
    assign oSTROBE = strobeReg;

endmodule

// File: doc/sd_demodulator.md
Name: sd_demodulator

Overview:
- 1-bit sigma-delta audio input path. Counterpart of the existing 8-bit sigma-delta DAC modulator on the MKR analog pins.
- An external comparator plus RC network forms a first-order sigma-delta ADC. This block re-times the comparator bit and drives the feedback pin.
- It decimates the bitstream with a 3rd-order CIC filter and emits unsigned PCM samples with a one-cycle strobe. Downstream consumers are audio loopback and VU-meter logic in the game/video top levels.

Parameters:
- pBITS, 8: output sample width; must satisfy pBITS <= 3*pDEC_BITS.
- pDEC_BITS, 5: log2 of decimation ratio R (R = 2^pDEC_BITS = 32 by default).

Ports:
- iCLK  input  1  system clock; all logic on the rising edge.
- iRESETn  input  1  asynchronous, active-low reset.
- iBIT  input  1  raw comparator bit from the MKR pin; asynchronous to iCLK.
- oFB  output  1  feedback bit to the external RC integrator.
- oDATA  output  pBITS  decimated unsigned PCM sample.
- oSTROBE  output  1  one-cycle pulse; oDATA is new in this cycle.

Behaviour:
- Reset (async assert, sync release): all registers clear. oFB=0, oDATA=0, oSTROBE=0, decimation counter=0, warm-up counter=0.
- Synchronizer:
  - iBIT passes through two flops, s1 then s2. s2 is the filter input x (0 or 1, unsigned).
  - oFB = s2, registered; no inversion.
- Integrators:
  - Width W = 3*pDEC_BITS+1 (16 by default).
  - Three cascaded registered accumulators: i1 += x, i2 += i1, i3 += i2, all modulo 2^W.
  - Wrap-around is intentional and must not saturate; CIC modular arithmetic cancels it.
- Decimation counter:
  - pDEC_BITS wide, free-running 0..R-1, wraps to 0.
  - Terminal count (tc) is counter == R-1.
- Comb stage:
  - On the tc edge, latch i3 into c0 and shift the comb delay line: c1 <= c0, c2 <= c1, c3 <= c2.
  - The combinational difference y = c0 - 3*c1 + 3*c2 - c3 is evaluated mod 2^W (equivalent to three cascaded first differences).
- Output register, on the edge after tc:
  - Saturate: ys = (y == 2^(W-1)) ? 2^(W-1)-1 : y. Full-scale input yields exactly R^3 = 2^(W-1).
  - oDATA <= ys[W-2 : W-1-pBITS], i.e. ys >> (W-1-pBITS), truncating.
- oSTROBE:
  - Goes high for exactly one cycle on that same edge.
  - Strobe period is exactly R cycles.
  - Strobe-to-strobe spacing never varies.
- Warm-up:
  - A 3-bit counter increments on each internal strobe until it reaches 4.
  - The first 4 strobes after reset are suppressed: oSTROBE stays 0 and oDATA stays 0.
  - From the 5th strobe onward, outputs are normal.
- Latency: a change on iBIT reaches x after 2 edges. Filter group delay is (3R-3)/2 input cycles plus 5 pipeline cycles.
- Reset mid-operation:
  - Immediate clear of all state, including any in-flight sample.
  - Warm-up restarts and no partial strobe is emitted.
- Input glitches shorter than one clock period may be missed or caught; no requirement beyond metastability safety.

Test Plan:
- iBIT held 0 from reset for 10*R cycles:
  - oSTROBE never asserts for the first 4 periods.
  - It then pulses every 32 cycles with oDATA=0x00.
- iBIT held 1: after warm-up, oDATA=0xFF on every strobe (saturation path), and oFB=1 two cycles after iBIT rises.
- iBIT toggling 1,0,1,0 every cycle: after warm-up, every oDATA=0x80 exactly.
- iBIT pattern 1,0,0,0 repeating: after warm-up, every oDATA=0x40 exactly.
- Strobe timing: count cycles between consecutive oSTROBE pulses over 100 samples; the interval is always 32 and the pulse width is always 1.
- Reset mid-run:
  - Stimulus: run iBIT=1 to steady 0xFF, then assert iRESETn low for 3 cycles, between strobes.
  - Required: oDATA and oSTROBE drop to 0 asynchronously, and oFB=0.
  - After release, 4 periods pass with no strobe, then 0xFF resumes.
- Parameter sweep pDEC_BITS=3, pBITS=8 (W=10), constant 1 then constant 0: outputs 0xFF then, after the transient settles, 0x00.
